// File: rtl/video_timing_if.sv
// Core-side bundle for the raster timing generator: pixel enable, colour and
// sync offsets in, raster position, blanking, syncs and strobes out.
interface video_timing_if #(
    parameter int CW = 12
);
    logic          CE;
    logic [CW-1:0] iRGB;
    logic [3:0]    HOFS;
    logic [3:0]    VOFS;
    logic [9:0]    HPOS;
    logic [9:0]    VPOS;
    logic [CW-1:0] oRGB;
    logic          HBLK;
    logic          VBLK;
    logic          HSYN;
    logic          VSYN;
    logic          DE;
    logic          LINE;
    logic          FRAME;

    modport master (
        output CE, iRGB, HOFS, VOFS,
        input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE, FRAME
    );

    modport slave (
        input  CE, iRGB, HOFS, VOFS,
        output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, LINE, FRAME
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator on one clock, gated by a pixel enable.
// Sync windows shift by HOFS/VOFS, latched only at the frame boundary.
module video_timing_gen #(
    parameter int HACT      = 288,
    parameter int HFP       = 2,
    parameter int HSW       = 22,
    parameter int HBP       = 72,
    parameter int VACT      = 224,
    parameter int VFP       = 3,
    parameter int VSW       = 7,
    parameter int VBP       = 29,
    parameter int CW        = 12,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int MASK_COL0 = 1
) (
    input  logic         MCLK,
    input  logic         RESET,
    video_timing_if.slave vif
);
    localparam int HTOTAL = HACT + HFP + HSW + HBP;
    localparam int VTOTAL = VACT + VFP + VSW + VBP;

    localparam logic [9:0] H_LAST = 10'(HTOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(VTOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(HACT);
    localparam logic [9:0] V_ACT  = 10'(VACT);

    localparam logic signed [11:0] HS_NOM = 12'(HACT + HFP);
    localparam logic signed [11:0] HS_MIN = 12'(HACT);
    localparam logic signed [11:0] HS_MAX = 12'(HTOTAL - HSW);
    localparam logic signed [11:0] VS_NOM = 12'(VACT + VFP);
    localparam logic signed [11:0] VS_MIN = 12'(VACT);
    localparam logic signed [11:0] VS_MAX = 12'(VTOTAL - VSW);

    localparam logic HS_ACT_LVL = 1'(HS_POL);
    localparam logic VS_ACT_LVL = 1'(VS_POL);

    logic [9:0]          h, v;
    logic [3:0]          hofs_s, vofs_s;
    logic signed [11:0]  hs_raw, vs_raw;
    logic [11:0]         hs0, vs0;
    logic                h_wrap, f_wrap;
    logic                hblk_n, vblk_n, hs_act, vs_act, col0;

    logic [CW-1:0]       rgb_q;
    logic                hblk_q, vblk_q, hsyn_q, vsyn_q, line_q, frame_q;

    // Sync start = nominal + shadow offset, clamped so the pulse stays in blanking.
    always_comb begin
        hs_raw = HS_NOM + $signed({{8{hofs_s[3]}}, hofs_s});
        vs_raw = VS_NOM + $signed({{8{vofs_s[3]}}, vofs_s});
        hs0 = hs_raw;
        if (hs_raw < HS_MIN) hs0 = HS_MIN;
        else if (hs_raw > HS_MAX) hs0 = HS_MAX;
        vs0 = vs_raw;
        if (vs_raw < VS_MIN) vs0 = VS_MIN;
        else if (vs_raw > VS_MAX) vs0 = VS_MAX;
    end

    assign h_wrap = (h == H_LAST);
    assign f_wrap = h_wrap && (v == V_LAST);
    assign hblk_n = (h >= H_ACT);
    assign vblk_n = (v >= V_ACT);
    assign hs_act = ({2'b00, h} >= hs0) && ({2'b00, h} < hs0 + 12'(HSW));
    assign vs_act = ({2'b00, v} >= vs0) && ({2'b00, v} < vs0 + 12'(VSW));
    assign col0   = (MASK_COL0 != 0) && (h == 10'd0);

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            h       <= '0;
            v       <= '0;
            hofs_s  <= '0;
            vofs_s  <= '0;
            rgb_q   <= '0;
            hblk_q  <= 1'b1;
            vblk_q  <= 1'b1;
            hsyn_q  <= ~HS_ACT_LVL;
            vsyn_q  <= ~VS_ACT_LVL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (vif.CE) begin
                // Outputs describe the pre-increment position.
                hblk_q  <= hblk_n;
                vblk_q  <= vblk_n;
                hsyn_q  <= hs_act ? HS_ACT_LVL : ~HS_ACT_LVL;
                vsyn_q  <= vs_act ? VS_ACT_LVL : ~VS_ACT_LVL;
                rgb_q   <= (hblk_n || vblk_n || col0) ? '0 : vif.iRGB;
                line_q  <= h_wrap;
                frame_q <= f_wrap;
                if (h_wrap) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
                if (f_wrap) begin
                    hofs_s <= vif.HOFS;
                    vofs_s <= vif.VOFS;
                end
            end
        end
    end

    assign vif.HPOS  = h;
    assign vif.VPOS  = v;
    assign vif.oRGB  = rgb_q;
    assign vif.HBLK  = hblk_q;
    assign vif.VBLK  = vblk_q;
    assign vif.HSYN  = hsyn_q;
    assign vif.VSYN  = vsyn_q;
    assign vif.DE    = ~(hblk_q | vblk_q);
    assign vif.LINE  = line_q;
    assign vif.FRAME = frame_q;
endmodule
